// File: rtl/irda_tx_pkg.sv
// irda_tx_pkg: shared types and constants for the IrDA TX data controller.
//   state_e    - controller FSM states (IDLE, SHIFT, STARVED)
//   DATA_W_DEF - default word width
//   word_t     - one held word: data, last flag, bit limit, bit order.
//                Sized for the widest legal word; users take the low bits.
package irda_tx_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int MAX_W      = 64;   // widest legal DATA_W
    localparam int MAX_CW     = 6;    // $clog2(MAX_W)

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        STARVED = 2'd2
    } state_e;

    // lim is the index of the final valid bit, derived from nbits at capture.
    typedef struct packed {
        logic [MAX_W-1:0]  word;
        logic              last;
        logic [MAX_CW-1:0] lim;
        logic              msb;
    } word_t;

endpackage

// File: rtl/irda_tx_data_ctrl_if.sv
// irda_tx_data_ctrl_if: bus between the TX FIFO / bit-serialiser and the
// data controller.
//   slave  modport - the controller: takes control + FIFO head, drives the
//                    pop pulse and the current bit with its flags.
//   master modport - the environment side of the same signals.
interface irda_tx_data_ctrl_if
    import irda_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = $clog2(DATA_W)
);
    logic              dc_restart;
    logic              tx_enable;
    logic              next_data;
    logic              msb_first;
    logic              txfifo_empty;
    logic [DATA_W-1:0] txfifo_dat_o;
    logic              txfifo_last;
    logic [CNT_W:0]    txfifo_nbits;
    logic              txfifo_remove;
    logic              data_available;
    logic              data_o;
    logic              data_last;
    logic              underrun;

    modport slave (
        input  dc_restart, tx_enable, next_data, msb_first,
        input  txfifo_empty, txfifo_dat_o, txfifo_last, txfifo_nbits,
        output txfifo_remove, data_available, data_o, data_last, underrun
    );

    modport master (
        output dc_restart, tx_enable, next_data, msb_first,
        output txfifo_empty, txfifo_dat_o, txfifo_last, txfifo_nbits,
        input  txfifo_remove, data_available, data_o, data_last, underrun
    );
endinterface

// File: rtl/irda_tx_word_reg.sv
// irda_tx_word_reg: holds one word_t (word, last, bit limit, order).
//   clk, wb_rst_i - clock, async active-high reset
//   clr_i         - synchronous clear to zero (wins over ld_i)
//   ld_i, d_i     - load d_i on the next edge
//   q_o           - held word
module irda_tx_word_reg
    import irda_tx_pkg::*;
(
    input  logic  clk,
    input  logic  wb_rst_i,
    input  logic  clr_i,
    input  logic  ld_i,
    input  word_t d_i,
    output word_t q_o
);
    word_t hold_q;

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i)   hold_q <= '0;
        else if (clr_i) hold_q <= '0;
        else if (ld_i)  hold_q <= d_i;
    end

    assign q_o = hold_q;
endmodule

// File: rtl/irda_tx_data_ctrl.sv
// irda_tx_data_ctrl: pulls words from the TX FIFO and presents them one bit
// at a time (LSB- or MSB-first, captured per word) to the serialiser.
//   clk, wb_rst_i - clock, async active-high reset
//   bus (slave)   - dc_restart/tx_enable/next_data/msb_first and FIFO head
//                   in; txfifo_remove, data_available, data_o, data_last,
//                   underrun out.
// Build option: IRDA_TX_PREFETCH_EN adds a second word buffer that is filled
// while the current word shifts, so word boundaries never need the FIFO.
module irda_tx_data_ctrl
    import irda_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = $clog2(DATA_W)
)(
    input  logic clk,
    input  logic wb_rst_i,
    irda_tx_data_ctrl_if.slave bus
);
    localparam int NB_W = CNT_W + 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  ptr_q, ptr_d;
    logic              avail_q, avail_d;
    logic              remove_q, remove_d;
    logic              underrun_q, underrun_d;

    word_t             sr_q, sr_d, fifo_w;
    logic              sr_ld;
    logic [CNT_W-1:0]  fifo_lim, cur_lim, idx;
    logic [DATA_W-1:0] cur_word;
    logic              adv, fifo_ok, at_lim;
    logic              unused_hold;

    assign adv     = bus.next_data & bus.tx_enable;
    // A pop is in flight while remove_q is high; the head is stale then.
    assign fifo_ok = ~bus.txfifo_empty & ~remove_q;

    assign fifo_lim = (bus.txfifo_last && bus.txfifo_nbits != '0)
                    ? CNT_W'(bus.txfifo_nbits - NB_W'(1))
                    : CNT_W'(DATA_W - 1);

    always_comb begin
        fifo_w      = '0;
        fifo_w.word = MAX_W'(bus.txfifo_dat_o);
        fifo_w.last = bus.txfifo_last;
        fifo_w.lim  = MAX_CW'(fifo_lim);
        fifo_w.msb  = bus.msb_first;
    end

    assign cur_word    = sr_q.word[DATA_W-1:0];
    assign cur_lim     = sr_q.lim[CNT_W-1:0];
    assign at_lim      = (ptr_q == cur_lim);
    assign idx         = sr_q.msb ? (CNT_W'(DATA_W - 1) - ptr_q) : ptr_q;
    assign unused_hold = ^sr_q;

`ifdef IRDA_TX_PREFETCH_EN
    word_t pf_q;
    logic  pf_vld_q, pf_ld, pf_clr, sr_from_pf;

    irda_tx_word_reg u_pf (
        .clk(clk), .wb_rst_i(wb_rst_i), .clr_i(bus.dc_restart),
        .ld_i(pf_ld), .d_i(fifo_w), .q_o(pf_q)
    );

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i)    pf_vld_q <= 1'b0;
        else if (pf_clr) pf_vld_q <= 1'b0;
        else if (pf_ld)  pf_vld_q <= 1'b1;
    end

    assign sr_d = sr_from_pf ? pf_q : fifo_w;
`else
    assign sr_d = fifo_w;
`endif

    irda_tx_word_reg u_sr (
        .clk(clk), .wb_rst_i(wb_rst_i), .clr_i(bus.dc_restart),
        .ld_i(sr_ld), .d_i(sr_d), .q_o(sr_q)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        avail_d    = avail_q;
        remove_d   = 1'b0;
        underrun_d = 1'b0;
        sr_ld      = 1'b0;
`ifdef IRDA_TX_PREFETCH_EN
        pf_ld      = 1'b0;
        pf_clr     = 1'b0;
        sr_from_pf = 1'b0;
`endif
        if (bus.dc_restart) begin
            state_d = IDLE;
            ptr_d   = '0;
            avail_d = 1'b0;
`ifdef IRDA_TX_PREFETCH_EN
            pf_clr  = 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE, STARVED: begin
                    if (state_q == STARVED && adv) underrun_d = 1'b1;
                    if (fifo_ok) begin
                        sr_ld    = 1'b1;
                        remove_d = 1'b1;
                        ptr_d    = '0;
                        avail_d  = 1'b1;
                        state_d  = SHIFT;
                    end
                end
                SHIFT: begin
                    if (adv && !at_lim) begin
                        ptr_d = ptr_q + CNT_W'(1);
                    end else if (adv && sr_q.last) begin
                        avail_d = 1'b0;
                        state_d = IDLE;
                    end else if (adv) begin
`ifdef IRDA_TX_PREFETCH_EN
                        if (pf_vld_q) begin
                            sr_ld      = 1'b1;
                            sr_from_pf = 1'b1;
                            pf_clr     = 1'b1;
                            ptr_d      = '0;
                        end else
`endif
                        if (fifo_ok) begin
                            sr_ld    = 1'b1;
                            remove_d = 1'b1;
                            ptr_d    = '0;
                        end else begin
                            avail_d = 1'b0;
                            state_d = STARVED;
                        end
                    end
`ifdef IRDA_TX_PREFETCH_EN
                    // Skip the fill when a direct boundary load already pops.
                    if (!pf_vld_q && !sr_q.last && fifo_ok && !remove_d) begin
                        pf_ld    = 1'b1;
                        remove_d = 1'b1;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            avail_q    <= 1'b0;
            remove_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            avail_q    <= avail_d;
            remove_q   <= remove_d;
            underrun_q <= underrun_d;
        end
    end

    assign bus.txfifo_remove  = remove_q;
    assign bus.data_available = avail_q;
    assign bus.data_o         = avail_q & cur_word[idx];
    // sr keeps the finished word after a frame ends, so gate with avail.
    assign bus.data_last      = avail_q & sr_q.last & at_lim;
    assign bus.underrun       = underrun_q;
endmodule

// File: tb/tb_irda_tx_data_ctrl.sv
`timescale 1ns/1ps
module tb_irda_tx_data_ctrl;
    localparam int DW = 32;
    localparam int CW = 5;
    localparam int NW = CW + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    irda_tx_data_ctrl_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
    irda_tx_data_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (.clk(clk), .wb_rst_i(rst), .bus(bus));

    typedef struct { logic [DW-1:0] w; bit last; int nbits; bit msb; } fent_t;
    typedef struct { bit b; bit last; } ebit_t;

    fent_t fq[$];     // FIFO contents as the design should see them
    ebit_t bq[$];     // bits the design still owes, in order
    int    checks = 0, failures = 0, removes = 0;
    bit    in_frame = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_avail"},  bus.data_available, 0);
        chk({tag, "_data"},   bus.data_o, 0);
        chk({tag, "_last"},   bus.data_last, 0);
        chk({tag, "_remove"}, bus.txfifo_remove, 0);
        chk({tag, "_under"},  bus.underrun, 0);
    endtask

    task automatic drive_fifo();
        bus.txfifo_empty = (fq.size() == 0);
        if (fq.size() > 0) begin
            bus.txfifo_dat_o = fq[0].w;
            bus.txfifo_last  = fq[0].last;
            bus.txfifo_nbits = NW'(fq[0].nbits);
            bus.msb_first    = fq[0].msb;
        end
    endtask

    task automatic push(input logic [DW-1:0] w, input bit last, input int nbits, input bit msb);
        fent_t e;
        e = '{w: w, last: last, nbits: nbits, msb: msb};
        fq.push_back(e);
        drive_fifo();
    endtask

    // A consumed word turns into its bit sequence per the order/length rules.
    task automatic pop_word();
        fent_t e;
        int nb;
        if (fq.size() == 0) begin chk("pop_on_empty", 1, 0); return; end
        e  = fq.pop_front();
        nb = (e.last && e.nbits != 0) ? e.nbits : DW;
        for (int i = 0; i < nb; i++)
            bq.push_back('{b: (e.msb ? e.w[DW-1-i] : e.w[i]), last: (e.last && i == nb-1)});
        removes++;
        drive_fifo();
    endtask

    // One clock: check current bit, issue request, check underrun, track pops.
    task automatic cyc(input bit req, input bit en);
        bit    exp_un;
        ebit_t h;
        if (bus.data_available) begin
            if (bq.size() == 0) chk("bit_unexpected", 1, 0);
            else begin
                chk("data_o", bus.data_o, bq[0].b);
                chk("data_last", bus.data_last, bq[0].last);
            end
        end else begin
            chk("idle_data_o", bus.data_o, 0);
            chk("idle_data_last", bus.data_last, 0);
        end
        exp_un = req && en && !bus.data_available && in_frame;
        if (req && en && bus.data_available && bq.size() > 0) begin
            h = bq.pop_front();
            in_frame = !h.last;
        end
        bus.next_data = req;
        bus.tx_enable = en;
        @(posedge clk);
        @(negedge clk);
        bus.next_data = 1'b0;
        chk("underrun", bus.underrun, exp_un);
        if (bus.txfifo_remove) pop_word();
    endtask

    task automatic wait_avail(input string tag);
        for (int k = 0; k < 8 && !bus.data_available; k++) cyc(0, 1);
        chk({tag, "_wait_avail"}, bus.data_available, 1);
    endtask

    task automatic model_clear();
        fq.delete();
        bq.delete();
        in_frame = 1'b0;
        drive_fifo();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        bus.dc_restart = 0; bus.tx_enable = 0; bus.next_data = 0; bus.msb_first = 0;
        bus.txfifo_empty = 1; bus.txfifo_dat_o = '0; bus.txfifo_last = 0; bus.txfifo_nbits = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Full LSB-first word, then starve, underrun, resume with partial MSB-first last word
        r0 = removes;
        push(32'hA5A5_0001, 0, 0, 0);
        cyc(0, 1);
        chk("load_avail", bus.data_available, 1);
        chk("first_bit", bus.data_o, 1);
        repeat (32) cyc(1, 1);
        chk("one_remove", removes - r0, 1);
        chk("starved_avail", bus.data_available, 0);
        cyc(1, 1);
        chk("underrun_seen", bus.underrun, 1);
        cyc(0, 1);
        push(32'h0000_0013, 1, 5, 1);
        cyc(0, 1);
        chk("resume_avail", bus.data_available, 1);
        repeat (4) cyc(1, 1);
        chk("partial_last5", bus.data_last, 1);
        cyc(1, 1);
        chk("frame_end_avail", bus.data_available, 0);

        // Gapless boundary across two queued words
        r0 = removes;
        push($urandom(), 0, 0, $urandom_range(0, 1));
        push($urandom(), 0, 0, $urandom_range(0, 1));
        wait_avail("gapless");
        for (int i = 0; i < 64; i++) begin
            chk("gapless_avail", bus.data_available, 1);
            cyc(1, 1);
        end
        chk("gapless_removes", removes - r0, 2);
        chk("gapless_starved", bus.data_available, 0);

        // Restart at ptr=10 with a second word queued/prefetched
        push($urandom(), 0, 0, 0);
        push($urandom(), 0, 0, 1);
        wait_avail("restart");
        repeat (10) cyc(1, 1);
        cyc(0, 1);
        cyc(0, 1);
        r0 = removes;
        bus.dc_restart = 1'b1;
        fq.delete();
        drive_fifo();
        cyc(0, 0);
        bus.dc_restart = 1'b0;
        model_clear();
        chk_zero("restart");
        repeat (3) cyc(1, 1);
        chk("restart_no_pop", removes - r0, 0);

        // Gating: requests with tx_enable=0 leave the bit position alone
        push(32'h0000_00F0, 0, 0, 0);
        wait_avail("gate");
        repeat (3) cyc(1, 1);
        repeat (8) cyc(1, 0);
        chk("gate_bit3", bus.data_o, 0);
        cyc(1, 1);
        chk("gate_bit4", bus.data_o, 1);
        cyc(1, 1);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Randomised traffic against the bit-stream model
        for (int n = 0; n < 900; n++) begin
            if (fq.size() < 3 && $urandom_range(0, 3) == 0)
                push($urandom(), ($urandom_range(0, 3) == 0), $urandom_range(0, DW), $urandom_range(0, 1));
            cyc($urandom_range(0, 1), ($urandom_range(0, 3) != 0));
        end
        push($urandom(), 1, 0, $urandom_range(0, 1));
        for (int k = 0; k < 2000 && !(fq.size() == 0 && bq.size() == 0 && !bus.data_available); k++)
            cyc(1, 1);
        chk("drain_done", (fq.size() == 0 && bq.size() == 0 && !bus.data_available), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
